// File: rtl/aq_gemac_pkg.sv
// Shared constants and types for the GEMAC receive path.
package aq_gemac_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         MIN_FRAME_LEN = 64;
  localparam int         FCS_LEN       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic        crc_err;
    logic        rx_er;
    logic        runt;
    logic        too_long;
    logic [15:0] length;
  } rx_status_t;
endpackage

// File: rtl/aq_gemac_rx_fcs_strip.sv
// FCS_LEN-deep byte delay line: a byte leaves only once FCS_LEN newer bytes follow it,
// so the trailing FCS never gets out.
module aq_gemac_rx_fcs_strip
  import aq_gemac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] din,
  output logic       emit,
  output logic [7:0] dout
);
  logic [FCS_LEN-1:0][7:0] line;
  logic [2:0]              fill;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      line <= '0;
      fill <= '0;
    end else if (push) begin
      line <= {line[FCS_LEN-2:0], din};
      if (fill != 3'(FCS_LEN)) fill <= fill + 3'd1;
    end
  end

  assign emit = push && (fill == 3'(FCS_LEN));
  assign dout = line[FCS_LEN-1];
endmodule

// File: rtl/aq_gemac_rx_frame.sv
// GMII receive framer: strips preamble/SFD, feeds the Rx CRC checker, forwards frame
// bytes (optionally without FCS) and commits a one-cycle status word per frame.
module aq_gemac_rx_frame
  import aq_gemac_pkg::*;
#(
  parameter int STRIP_FCS = 1,
  parameter int MAX_LEN   = 1518
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_DV,
  input  logic        RX_ER,
  input  logic [7:0]  RXD,
  output logic [7:0]  CRC_DATA,
  output logic        CRC_INIT,
  output logic        CRC_ENABLE,
  input  logic        CRC_ERR,
  output logic        OUT_VALID,
  output logic        OUT_SOF,
  output logic [7:0]  OUT_DATA,
  output logic        STATUS_VALID,
  output logic        STATUS_CRC_ERR,
  output logic        STATUS_RX_ER,
  output logic        STATUS_RUNT,
  output logic        STATUS_LONG,
  output logic [15:0] STATUS_LENGTH
);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_FRAME_LEN);

  logic       dv_q, er_q;
  logic [7:0] rxd_q;
  rx_state_e  state;
  logic [15:0] len;
  logic       err_seen, sof_pend;
  rx_status_t status;

  logic       push, end_hit, sfd_hit, emit;
  logic [7:0] emit_data;

  assign push    = (state == ST_DATA) && dv_q;
  assign end_hit = (state == ST_DATA) && !dv_q;
  assign sfd_hit = ((state == ST_IDLE) || (state == ST_PRE)) && dv_q && !er_q &&
                   (rxd_q == SFD_BYTE);

  // The checker sees every DATA byte; its register is complete in the end cycle.
  assign CRC_DATA   = rxd_q;
  assign CRC_ENABLE = push;
  assign CRC_INIT   = (state != ST_DATA);

  generate
    if (STRIP_FCS != 0) begin : g_strip
      aq_gemac_rx_fcs_strip u_strip (
        .clk   (CLK),
        .rst   (RST),
        .clear (sfd_hit || end_hit),
        .push  (push),
        .din   (rxd_q),
        .emit  (emit),
        .dout  (emit_data)
      );
    end else begin : g_bypass
      assign emit      = push;
      assign emit_data = rxd_q;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      rxd_q <= '0;
    end else begin
      dv_q  <= RX_DV;
      er_q  <= RX_ER;
      rxd_q <= RXD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      len          <= '0;
      err_seen     <= 1'b0;
      sof_pend     <= 1'b0;
      status       <= '0;
      STATUS_VALID <= 1'b0;
      OUT_VALID    <= 1'b0;
      OUT_SOF      <= 1'b0;
      OUT_DATA     <= '0;
    end else begin
      STATUS_VALID <= 1'b0;
      OUT_VALID    <= emit;
      OUT_SOF      <= emit && sof_pend;
      OUT_DATA     <= emit ? emit_data : 8'h00;
      if (emit) sof_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dv_q) begin
            if (er_q)                        state <= ST_DROP;
            else if (rxd_q == PREAMBLE_BYTE) state <= ST_PRE;
            else if (rxd_q == SFD_BYTE)      state <= ST_DATA;
            else                             state <= ST_DROP;
          end
        end
        ST_PRE: begin
          if (!dv_q)                       state <= ST_IDLE;
          else if (er_q)                   state <= ST_DROP;
          else if (rxd_q == SFD_BYTE)      state <= ST_DATA;
          else if (rxd_q != PREAMBLE_BYTE) state <= ST_DROP;
        end
        ST_DATA: begin
          if (dv_q) begin
            if (len != 16'hFFFF) len <= len + 16'd1;
            err_seen <= err_seen | er_q;
          end else begin
            status.crc_err  <= CRC_ERR;
            status.rx_er    <= err_seen;
            status.runt     <= (len < MIN_LEN_W);
            status.too_long <= (len > MAX_LEN_W);
            status.length   <= len;
            STATUS_VALID    <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        ST_DROP: if (!dv_q) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (sfd_hit) begin
        len      <= '0;
        err_seen <= 1'b0;
        sof_pend <= 1'b1;
      end
    end
  end

  assign STATUS_CRC_ERR = status.crc_err;
  assign STATUS_RX_ER   = status.rx_er;
  assign STATUS_RUNT    = status.runt;
  assign STATUS_LONG    = status.too_long;
  assign STATUS_LENGTH  = status.length;
endmodule

// File: tb/tb_aq_gemac_rx_frame.sv
// Directed bench for the GMII receive framer with a behavioural CRC checker alongside
// and a frame-level expectation model checked every cycle.
module tb_aq_gemac_rx_frame;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX_DV = 1'b0, RX_ER = 1'b0;
  logic [7:0]  RXD = 8'h00;
  logic [7:0]  CRC_DATA;
  logic        CRC_INIT, CRC_ENABLE, CRC_ERR;
  logic        OUT_VALID, OUT_SOF, STATUS_VALID;
  logic [7:0]  OUT_DATA;
  logic        STATUS_CRC_ERR, STATUS_RX_ER, STATUS_RUNT, STATUS_LONG;
  logic [15:0] STATUS_LENGTH;

  aq_gemac_rx_frame #(.STRIP_FCS(1), .MAX_LEN(1518)) dut (
    .CLK(CLK), .RST(RST), .RX_DV(RX_DV), .RX_ER(RX_ER), .RXD(RXD),
    .CRC_DATA(CRC_DATA), .CRC_INIT(CRC_INIT), .CRC_ENABLE(CRC_ENABLE), .CRC_ERR(CRC_ERR),
    .OUT_VALID(OUT_VALID), .OUT_SOF(OUT_SOF), .OUT_DATA(OUT_DATA),
    .STATUS_VALID(STATUS_VALID), .STATUS_CRC_ERR(STATUS_CRC_ERR), .STATUS_RX_ER(STATUS_RX_ER),
    .STATUS_RUNT(STATUS_RUNT), .STATUS_LONG(STATUS_LONG), .STATUS_LENGTH(STATUS_LENGTH)
  );

  always #4 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [7:0] d; logic sof; } exp_b_t;
  typedef struct { logic crc; logic rxer; logic runt; logic lng; logic [15:0] len; } exp_s_t;
  exp_b_t qb[$];
  exp_s_t qs[$];
  logic [7:0] frm[$];
  int n_out, n_stat;
  logic [15:0] last_len;
  logic last_crc, last_rxer, last_runt, last_lng;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int b = 0; b < 8; b++) r = (r >> 1) ^ ((r[0] ^ d[b]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_step(c, q[i]);
    return ~c;
  endfunction

  // Stand-in for the sibling Rx CRC checker: residue of a good frame is DEBB20E3.
  logic [31:0] crc_reg;
  always @(posedge CLK) begin
    if (RST || CRC_INIT) crc_reg <= 32'hFFFFFFFF;
    else if (CRC_ENABLE) crc_reg <= crc_step(crc_reg, CRC_DATA);
  end
  assign CRC_ERR = (crc_reg != 32'hDEBB20E3);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_b_t eb;
    exp_s_t es;
    if (OUT_VALID || STATUS_VALID) chk("out_status_exclusive", OUT_VALID & STATUS_VALID, 0);
    if (OUT_VALID) begin
      n_out++;
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got byte %0h expected none", OUT_DATA);
      end else begin
        eb = qb.pop_front();
        chk("out_data", OUT_DATA, eb.d);
        chk("out_sof", OUT_SOF, eb.sof);
      end
    end
    if (STATUS_VALID) begin
      n_stat++;
      {last_crc, last_rxer, last_runt, last_lng, last_len} =
        {STATUS_CRC_ERR, STATUS_RX_ER, STATUS_RUNT, STATUS_LONG, STATUS_LENGTH};
      if (qs.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_status: got length %0d expected none", STATUS_LENGTH);
      end else begin
        es = qs.pop_front();
        chk("status_fields", {STATUS_CRC_ERR, STATUS_RX_ER, STATUS_RUNT, STATUS_LONG, STATUS_LENGTH},
            {es.crc, es.rxer, es.runt, es.lng, es.len});
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    RX_DV = dv; RX_ER = er; RXD = d;
    tick();
  endtask

  task automatic mk(input int n_pay);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < n_pay; i++) frm.push_back(8'($urandom_range(0, 255)));
    c = crc32(frm, n_pay);
    frm.push_back(c[7:0]); frm.push_back(c[15:8]);
    frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask

  // Model: all but the last 4 bytes come out; status is judged from frame contents.
  // A reset at byte k keeps only the bytes whose 6-cycle latency lands before it.
  task automatic send(input int npre, input int er_pre, input int er_at, input int rst_at,
                      input int gap);
    int n = frm.size();
    int n_emit = (rst_at >= 0) ? rst_at - 5 : n - 4;
    exp_s_t es;
    if (er_pre < 0) begin
      for (int i = 0; i < n_emit; i++) qb.push_back('{d: frm[i], sof: (i == 0)});
      if (rst_at < 0) begin
        es.crc  = (crc32(frm, n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
        es.rxer = (er_at >= 0);
        es.runt = (n < 64);
        es.lng  = (n > 1518);
        es.len  = 16'(n);
        qs.push_back(es);
      end
    end
    for (int i = 0; i < npre; i++) drive(1'b1, (i == er_pre), 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        RX_DV = 1'b0; RX_ER = 1'b0; RXD = 8'h00; RST = 1'b1;
        tick();
        chk("post_rst_outputs", {OUT_VALID, OUT_SOF, OUT_DATA, STATUS_VALID, STATUS_CRC_ERR,
            STATUS_RX_ER, STATUS_RUNT, STATUS_LONG, STATUS_LENGTH, CRC_ENABLE, CRC_DATA}, 0);
        chk("post_rst_crc_init", CRC_INIT, 1);
        RST = 1'b0;
        break;
      end
      drive(1'b1, (i == er_at), frm[i]);
    end
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    repeat (12) drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outputs", {OUT_VALID, OUT_SOF, OUT_DATA, STATUS_VALID, STATUS_CRC_ERR,
        STATUS_RX_ER, STATUS_RUNT, STATUS_LONG, STATUS_LENGTH, CRC_ENABLE}, 0);
    chk("reset_crc_init", CRC_INIT, 1);
    RST = 1'b0;
    tick();

    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    chk("crc_model_pin", crc32(frm, 9), 32'hCBF43926);

    // Good 64-byte frame after a full preamble.
    n_out = 0; n_stat = 0; mk(60); send(7, -1, -1, -1, 1); drain();
    chk("t1_nout", n_out, 60); chk("t1_nstat", n_stat, 1);
    chk("t1_len", last_len, 64); chk("t1_crc", last_crc, 0); chk("t1_runt", last_runt, 0);

    // One payload bit flipped after FCS computed.
    n_out = 0; n_stat = 0; mk(60); frm[10] = frm[10] ^ 8'h04; send(7, -1, -1, -1, 1); drain();
    chk("t2_nout", n_out, 60); chk("t2_crc", last_crc, 1); chk("t2_len", last_len, 64);

    // SFD straight from idle, 60-byte runt.
    n_out = 0; n_stat = 0; mk(56); send(0, -1, -1, -1, 1); drain();
    chk("t3_nout", n_out, 56); chk("t3_runt", last_runt, 1); chk("t3_crc", last_crc, 0);

    // RX_ER at frame byte 20.
    n_out = 0; n_stat = 0; mk(60); send(7, -1, 20, -1, 1); drain();
    chk("t4_rxer", last_rxer, 1); chk("t4_nstat", n_stat, 1);

    // RX_ER inside the preamble drops the frame.
    n_out = 0; n_stat = 0; mk(60); send(7, 1, -1, -1, 1); drain();
    chk("t5_nout", n_out, 0); chk("t5_nstat", n_stat, 0);

    // 1519-byte frame is long.
    n_out = 0; n_stat = 0; mk(1515); send(7, -1, -1, -1, 1); drain();
    chk("t6_nout", n_out, 1515); chk("t6_long", last_lng, 1); chk("t6_len", last_len, 1519);

    // Two frames with a single idle sample between them.
    n_out = 0; n_stat = 0;
    mk(60); send(7, -1, -1, -1, 1);
    mk(60); send(7, -1, -1, -1, 1); drain();
    chk("t7_nstat", n_stat, 2); chk("t7_nout", n_out, 120); chk("t7_crc", last_crc, 0);

    // Reset at frame byte 30, then a clean frame.
    n_out = 0; n_stat = 0; mk(60); send(7, -1, -1, 30, 2); drain();
    chk("t8_nout", n_out, 25); chk("t8_nstat", n_stat, 0);
    n_out = 0; n_stat = 0; mk(60); send(7, -1, -1, -1, 1); drain();
    chk("t8b_nout", n_out, 60); chk("t8b_nstat", n_stat, 1); chk("t8b_len", last_len, 64);

    chk("bytes_left", qb.size(), 0);
    chk("status_left", qs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
